// File: rtl/zegar_rtc_mux.sv
// rtl/zegar_rtc_mux.sv - BCD real-time clock with debounced set buttons and 8-digit 7-segment scan
module zegar_rtc_mux #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TEST_DIV        = 1_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000,
    parameter int SCAN_CYCLES     = 100_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       button_test_i,
    input  logic       button_hr_i,
    input  logic       button_min_i,
    output logic       tick_o,
    output logic [7:0] hh_o,
    output logic [7:0] mm_o,
    output logic [7:0] ss_o,
    output logic [7:0] led7_seg_o,
    output logic [7:0] led7_an_o
);

    localparam int MAX_DIV = (CLK_HZ > TEST_DIV) ? CLK_HZ : TEST_DIV;
    localparam int PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW      = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int SW      = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    localparam logic [PW-1:0] TC_NORM  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] TC_TEST  = PW'(TEST_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    localparam logic [SW-1:0] SC_LAST  = SW'(SCAN_CYCLES - 1);

    localparam logic [7:0] SEG_DASH = 8'b1011_1111;

    // Button bit order: 0 = test, 1 = hour, 2 = minute
    logic [2:0]         raw;
    logic [2:0]         sync1_q, sync2_q;
    logic [2:0]         db_q, db_d, db_chg;
    logic [2:0][DW-1:0] db_cnt_q, db_cnt_d;

    // Set-event bit order: 0 = hour, 1 = minute
    logic [1:0]         prev_q;
    logic [1:0][RW-1:0] rep_q, rep_d;
    logic [1:0]         ev;

    logic [PW-1:0] pre_q, pre_d;
    logic [PW-1:0] tc;
    logic          wrap;
    logic          tick_q;

    logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;

    logic [SW-1:0] sc_q, sc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    an_q, an_d, seg_q, seg_d;

    assign raw = {button_min_i, button_hr_i, button_test_i};

    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] hex7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Two-flop synchronisers for the raw buttons
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES in a row
    always_comb begin
        db_d     = db_q;
        db_chg   = '0;
        db_cnt_d = '0;
        for (int b = 0; b < 3; b++) begin
            if (sync2_q[b] != db_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    db_d[b]   = sync2_q[b];
                    db_chg[b] = 1'b1;
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Debounced levels and their stability counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            db_q     <= '0;
            db_cnt_q <= '0;
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Set events: debounced rising edge, then one more every REPEAT_CYCLES while held
    always_comb begin
        ev    = '0;
        rep_d = '0;
        for (int i = 0; i < 2; i++) begin
            ev[i] = (db_q[i+1] & ~prev_q[i]) |
                    (db_q[i+1] & prev_q[i] & (rep_q[i] == REP_LAST));
            if (db_q[i+1] && !ev[i])
                rep_d[i] = rep_q[i] + 1'b1;
        end
    end

    // Edge-detect history and repeat counters for the hour/minute buttons
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prev_q <= '0;
            rep_q  <= '0;
        end else begin
            prev_q <= db_q[2:1];
            rep_q  <= rep_d;
        end
    end

    // Prescaler next state; a mode change restarts the count so the first tick is a full period away
    always_comb begin
        tc    = db_q[0] ? TC_TEST : TC_NORM;
        wrap  = !db_chg[0] && (pre_q == tc);
        pre_d = pre_q + 1'b1;
        if (db_chg[0] || wrap)
            pre_d = '0;
    end

    // Prescaler and tick pulse register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= wrap;
        end
    end

    // Time next state: set events win over a coincident tick, which is then dropped
    always_comb begin
        hh_d = hh_q;
        mm_d = mm_q;
        ss_d = ss_q;
        if (ev[0] || ev[1]) begin
            if (ev[1]) begin
                mm_d = bcd_next(mm_q, 8'h59);
                ss_d = 8'h00;
            end
            if (ev[0])
                hh_d = bcd_next(hh_q, 8'h23);
        end else if (wrap) begin
            ss_d = bcd_next(ss_q, 8'h59);
            if (ss_q == 8'h59) begin
                mm_d = bcd_next(mm_q, 8'h59);
                if (mm_q == 8'h59)
                    hh_d = bcd_next(hh_q, 8'h23);
            end
        end
    end

    // BCD time registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hh_q <= 8'h00;
            mm_q <= 8'h00;
            ss_q <= 8'h00;
        end else begin
            hh_q <= hh_d;
            mm_q <= mm_d;
            ss_q <= ss_d;
        end
    end

    // Scan timing and digit pattern; index walks 0,7,6,...,1,0
    always_comb begin
        sc_d  = sc_q + 1'b1;
        idx_d = idx_q;
        if (sc_q == SC_LAST) begin
            sc_d  = '0;
            idx_d = idx_q - 3'd1;
        end
        an_d = ~(8'b1 << idx_q);
        case (idx_q)
            3'd7:    seg_d = hex7(hh_q[7:4]);
            3'd6:    seg_d = hex7(hh_q[3:0]);
            3'd5:    seg_d = SEG_DASH;
            3'd4:    seg_d = hex7(mm_q[7:4]);
            3'd3:    seg_d = hex7(mm_q[3:0]);
            3'd2:    seg_d = SEG_DASH;
            3'd1:    seg_d = hex7(ss_q[7:4]);
            default: seg_d = hex7(ss_q[3:0]) & {~db_q[0], 7'h7F};
        endcase
    end

    // Scan counter, digit index, and the anode/segment pair registered together
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sc_q  <= '0;
            idx_q <= 3'd0;
            an_q  <= 8'hFE;
            seg_q <= 8'hC0;
        end else begin
            sc_q  <= sc_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign tick_o     = tick_q;
    assign hh_o       = hh_q;
    assign mm_o       = mm_q;
    assign ss_o       = ss_q;
    assign led7_an_o  = an_q;
    assign led7_seg_o = seg_q;

endmodule

// File: tb/tb_zegar_rtc_mux.sv
// tb/tb_zegar_rtc_mux.sv - directed self-checking bench for zegar_rtc_mux
module tb_zegar_rtc_mux;

    logic       clk_i;
    logic       rst_i;
    logic       button_test_i;
    logic       button_hr_i;
    logic       button_min_i;
    logic       tick_o;
    logic [7:0] hh_o, mm_o, ss_o;
    logic [7:0] led7_seg_o, led7_an_o;

    int n_cmp;
    int n_bad;
    int cyc;
    int ticks;

    logic [7:0] an_tab  [8];
    logic [7:0] seg_tab [8];

    zegar_rtc_mux #(
        .CLK_HZ          (10),
        .TEST_DIV        (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (20),
        .SCAN_CYCLES     (3)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .button_test_i (button_test_i),
        .button_hr_i   (button_hr_i),
        .button_min_i  (button_min_i),
        .tick_o        (tick_o),
        .hh_o          (hh_o),
        .mm_o          (mm_o),
        .ss_o          (ss_o),
        .led7_seg_o    (led7_seg_o),
        .led7_an_o     (led7_an_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic expect_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target)
            step();
    endtask

    task automatic do_reset();
        rst_i         = 1'b0;
        button_test_i = 1'b0;
        button_hr_i   = 1'b0;
        button_min_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        an_tab  = '{8'hFE, 8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD};
        seg_tab = '{8'h82, 8'hF9, 8'hA4, 8'hBF, 8'hB0, 8'h99, 8'hBF, 8'h92};

        // Reset state and free-run
        rst_i = 1'b0; button_test_i = 1'b0; button_hr_i = 1'b0; button_min_i = 1'b0;
        repeat (3) @(negedge clk_i);
        expect_eq("rst_hh",   hh_o, 8'h00);
        expect_eq("rst_mm",   mm_o, 8'h00);
        expect_eq("rst_ss",   ss_o, 8'h00);
        expect_eq("rst_tick", 8'(tick_o), 8'h00);
        expect_eq("rst_an",   led7_an_o, 8'hFE);
        expect_eq("rst_seg",  led7_seg_o, 8'hC0);
        rst_i = 1'b1;
        cyc   = 0;
        ticks = 0;
        while (cyc < 600) begin
            step();
            if (tick_o) begin
                ticks++;
                expect_eq("tick_phase", 8'(cyc % 10), 8'h00);
            end
            if (cyc == 10) expect_eq("first_sec", ss_o, 8'h01);
        end
        expect_eq("free_ticks", 8'(ticks), 8'd60);
        expect_eq("free_ss", ss_o, 8'h00);
        expect_eq("free_mm", mm_o, 8'h01);
        expect_eq("free_hh", hh_o, 8'h00);

        // Debounce: bouncing minute button gives nothing, a 6-cycle hold gives one event
        do_reset();
        for (int i = 0; i < 20; i++) begin
            button_min_i = ((i / 2) % 2 == 0);
            step();
        end
        expect_eq("bounce_mm", mm_o, 8'h00);
        expect_eq("bounce_ss", ss_o, 8'h02);
        button_min_i = 1'b1;
        step_to(26);
        expect_eq("hold_pre_mm", mm_o, 8'h00);
        button_min_i = 1'b0;
        step();
        expect_eq("hold_mm", mm_o, 8'h01);
        expect_eq("hold_ss", ss_o, 8'h00);
        step_to(45);
        expect_eq("after_mm", mm_o, 8'h01);
        expect_eq("after_ss", ss_o, 8'h02);

        // Full wrap: preload 23:59 with repeating hr+min events, then count 60 ticks
        do_reset();
        button_hr_i  = 1'b1;
        button_min_i = 1'b1;
        step_to(447);
        expect_eq("pre_hh23", hh_o, 8'h23);
        button_hr_i = 1'b0;
        step_to(1167);
        expect_eq("pre_hh", hh_o, 8'h23);
        expect_eq("pre_mm", mm_o, 8'h59);
        expect_eq("pre_ss", ss_o, 8'h00);
        button_min_i = 1'b0;
        step_to(1759);
        expect_eq("w59_hh", hh_o, 8'h23);
        expect_eq("w59_mm", mm_o, 8'h59);
        expect_eq("w59_ss", ss_o, 8'h59);
        expect_eq("w59_tick", 8'(tick_o), 8'h00);
        step();
        expect_eq("wrap_hh", hh_o, 8'h00);
        expect_eq("wrap_mm", mm_o, 8'h00);
        expect_eq("wrap_ss", ss_o, 8'h00);
        expect_eq("wrap_tick", 8'(tick_o), 8'h01);
        step();
        expect_eq("wrap_tick_end", 8'(tick_o), 8'h00);

        // Auto-repeat: from 22 hold hr 70 cycles -> 23, 00, 01, 02
        do_reset();
        button_hr_i = 1'b1;
        step_to(427);
        expect_eq("ar_hh22", hh_o, 8'h22);
        button_hr_i = 1'b0;
        step_to(440);
        button_hr_i = 1'b1;
        step_to(446);
        expect_eq("ar_before", hh_o, 8'h22);
        step();
        expect_eq("ar_first", hh_o, 8'h23);
        step_to(466);
        expect_eq("ar_gap", hh_o, 8'h23);
        step();
        expect_eq("ar_rep1", hh_o, 8'h00);
        step_to(487);
        expect_eq("ar_rep2", hh_o, 8'h01);
        step_to(507);
        expect_eq("ar_rep3", hh_o, 8'h02);
        step_to(510);
        button_hr_i = 1'b0;
        step_to(540);
        expect_eq("ar_stop_hh", hh_o, 8'h02);
        expect_eq("ar_mm", mm_o, 8'h00);
        expect_eq("ar_ss", ss_o, 8'h54);

        // Test mode: 2-cycle ticks, dp on digit 0, event beats coincident tick
        do_reset();
        button_test_i = 1'b1;
        step_to(7);
        expect_eq("tm_notick7", 8'(tick_o), 8'h00);
        step();
        expect_eq("tm_tick8", 8'(tick_o), 8'h01);
        expect_eq("tm_an_d6", led7_an_o, 8'hBF);
        expect_eq("tm_seg_d6", led7_seg_o, 8'hC0);
        step();
        expect_eq("tm_notick9", 8'(tick_o), 8'h00);
        step();
        expect_eq("tm_tick10", 8'(tick_o), 8'h01);
        step_to(25);
        expect_eq("tm_an_d0", led7_an_o, 8'hFE);
        expect_eq("tm_seg_dp", led7_seg_o, 8'h10);
        step_to(31);
        button_min_i = 1'b1;
        step_to(37);
        expect_eq("tm_ss_pre", ss_o, 8'h15);
        expect_eq("tm_mm_pre", mm_o, 8'h00);
        button_min_i = 1'b0;
        step();
        expect_eq("tm_coll_ss", ss_o, 8'h00);
        expect_eq("tm_coll_mm", mm_o, 8'h01);
        expect_eq("tm_coll_tick", 8'(tick_o), 8'h01);
        step();
        expect_eq("tm_ss_hold", ss_o, 8'h00);
        step();
        expect_eq("tm_ss_next", ss_o, 8'h01);
        button_test_i = 1'b0;

        // Display scan at 12:34:56, then reset mid-scan
        do_reset();
        button_hr_i  = 1'b1;
        button_min_i = 1'b1;
        step_to(227);
        button_hr_i = 1'b0;
        step_to(667);
        expect_eq("ds_hh", hh_o, 8'h12);
        expect_eq("ds_mm", mm_o, 8'h34);
        button_min_i = 1'b0;
        step_to(1224);
        for (int k = 0; k < 24; k++) begin
            step();
            expect_eq("scan_an",  led7_an_o,  an_tab[k / 3]);
            expect_eq("scan_seg", led7_seg_o, seg_tab[k / 3]);
        end
        step_to(1250);
        rst_i = 1'b0;
        #1;
        expect_eq("mid_rst_an",  led7_an_o,  8'hFE);
        expect_eq("mid_rst_seg", led7_seg_o, 8'hC0);
        expect_eq("mid_rst_hh",  hh_o, 8'h00);
        expect_eq("mid_rst_mm",  mm_o, 8'h00);
        expect_eq("mid_rst_tick", 8'(tick_o), 8'h00);
        @(negedge clk_i);
        rst_i = 1'b1;
        cyc   = 0;
        step_to(30);
        expect_eq("post_rst_hh", hh_o, 8'h00);
        expect_eq("post_rst_mm", mm_o, 8'h00);
        expect_eq("post_rst_ss", ss_o, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/zegar_rtc_mux.md
# zegar_rtc_mux

Parametrised real-time clock: prescales the system clock to a 1 Hz tick and keeps BCD hours/minutes/seconds (24 h). It takes three debounced push-buttons (hour set and minute set with auto-repeat, plus a fast test mode) and drives an 8-digit multiplexed 7-segment display as HH-MM-SS. It replaces the fixed divider/clock block at the top level of the board design.

## Interface

Parameters:
- CLK_HZ, 100_000_000: system clock cycles per tick in normal mode.
- TEST_DIV, 1_000: clock cycles per tick in test mode.
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronised button level must stay stable before it is accepted.
- REPEAT_CYCLES, 25_000_000: hold time before the first auto-repeat, and the period between later repeats.
- SCAN_CYCLES, 100_000: cycles each display digit stays active.

Ports:
- clk_i, input, 1: system clock. Single clock domain.
- rst_i, input, 1: reset, asynchronous, active-low.
- button_test_i, input, 1: test-mode level (asynchronous, raw).
- button_hr_i, input, 1: hour-set button (asynchronous, raw, active-high).
- button_min_i, input, 1: minute-set button (asynchronous, raw, active-high).
- tick_o, output, 1: one-cycle pulse per counted second.
- hh_o, output, 8: hours in BCD, 00–23.
- mm_o, output, 8: minutes in BCD, 00–59.
- ss_o, output, 8: seconds in BCD, 00–59.
- led7_seg_o, output, 8: segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- led7_an_o, output, 8: digit anodes, active-low one-hot; bit 7 is the leftmost digit.

## Operation

- **Input conditioning:** each button passes through a 2-FF synchroniser.
  - A debounced level updates only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
- **Set events (hr, min):**
  - One event on the debounced rising edge.
  - If the button is still held REPEAT_CYCLES after an event, another event fires, and so on.
  - Release stops repeating and clears the repeat counter.
- **Test mode:** the debounced button_test_i level selects the terminal count: TEST_DIV when high, CLK_HZ when low. Any mode change clears the prescaler to 0.
- **Prescaler:** counts 0..N-1. When it reaches N-1 it wraps to 0 and a tick occurs. Width is $clog2(max(CLK_HZ,TEST_DIV)).
- **Time counters** (all BCD, per-digit arithmetic; binary values never appear on the outputs):
  - Tick: ss+1; 59→00 carries to mm+1; mm 59→00 carries to hh+1; hh 23→00.
  - Min event: mm+1 mod 60, ss←00, no carry into hh.
  - Hr event: hh+1 mod 24; mm and ss unchanged.
  - A min event and an hr event in the same cycle are both applied.
  - Any set event in the same cycle as a tick takes priority. That cycle's tick is discarded for counting, but tick_o still pulses.
- **Display:**
  - The digit index advances every SCAN_CYCLES cycles, 7→…→0 and then back to 7 (wraps).
  - Digit contents, left to right: H1 H0 '-' M1 M0 '-' S1 S0.
  - '-' = 8'b1011_1111. Hex 0–9 use the standard active-low patterns ('0'=8'hC0, '1'=8'hF9, '2'=8'hA4, …).
  - In test mode the dp of digit 0 is lit (seg bit 7 = 0). All other dps are off.
  - led7_an_o and led7_seg_o are registered together, so anode and segments never mismatch.

## Timing

- **Reset values** (rst_i low, asynchronous):
  - hh/mm/ss = 8'h00, tick_o = 0, prescaler 0.
  - Debounced levels 0, repeat and scan counters 0.
  - Display index 0: led7_an_o = 8'hFE, led7_seg_o = 8'hC0.
- **Tick timing:** tick_o rises on the edge where the prescaler wraps. ss_o/mm_o/hh_o change on that same edge. In normal mode, tick_o repeats every N cycles exactly.
- **Button latency:**
  - Raw rising edge to debounced level: 2 + DEBOUNCE_CYCLES cycles.
  - The set event is applied to the counters on the following edge (one registered stage).
- **Test-mode switch:** the first tick comes TEST_DIV (or CLK_HZ) cycles after the debounced level changes.
- **Display:** registered, one cycle after the index counter wraps; the segments shown reflect the time counters from one cycle earlier.
- **Reset mid-operation:** all state returns to reset values immediately. No event generated before reset is replayed after release.

## Test plan

Bench parameters: CLK_HZ=10, TEST_DIV=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20, SCAN_CYCLES=3.

- **Reset and free-run:** release reset, run 600 cycles → tick_o pulses every 10 cycles; after 60 ticks ss=00, mm=01, hh=00.
- **Full wrap:** preload via min/hr events to 23:59, run 60 ticks → 00:00:00 exactly on the 60th tick, tick_o single-cycle.
- **Debounce:** toggle button_min_i every 2 cycles for 20 cycles → no event. Hold high for 6 cycles → exactly one event: mm+1, ss=00.
- **Auto-repeat:** hold button_hr_i for 70 cycles from 22:xx → hh steps 23, 00, 01, 02 (first event plus 3 repeats), then stops on release.
- **Test mode:** raise button_test_i → after debounce, ticks every 2 cycles and digit-0 dp lit. Same-cycle min event and tick → ss=00, no extra second.
- **Display scan:** at 12:34:56 → anodes cycle FE,7F,BF,…,FD with 3 cycles each; segments per digit F9,A4,BF,B0,99,BF,92,82; assert rst_i low mid-scan → an=FE, seg=C0 immediately.
